// File: rtl/stress_pkg.sv
// Shared definitions for the stress calculator blocks.
//   state_t    : SAR level-finder control states
//   LEVEL_W    : width of a level / comparator trial value
//   SETTLE_MAX : largest supported comparator settling delay (cycles)
package stress_pkg;

    localparam int LEVEL_W    = 8;
    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);
    localparam int BIT_W      = $clog2(LEVEL_W);

    typedef enum logic {
        IDLE = 1'b0,
        TEST = 1'b1
    } state_t;

endpackage

// File: rtl/sar_level8_settle_timer.sv
// settle_timer: loadable down-counter that spaces comparator samples.
// After a load the counter runs SETTLE..0; tick is high while it sits at 0,
// which marks the cycle whose closing edge samples the comparator.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   load : reload with SETTLE (new candidate presented)
//   en   : count down one step
//   tick : sample cycle indicator
module settle_timer
    import stress_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    logic [SETTLE_W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= SETTLE_W'(SETTLE);
        else if (en && !tick)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/sar_level8.sv
// sar_level8: successive-approximation level finder.
// Presents trial values to an external "value > trial" comparator and
// resolves the 8-bit level MSB first, one bit per SETTLE+1 cycles.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   start  : begin a conversion (IDLE only; abort in the same cycle wins)
//   abort  : cancel a running conversion, no done, result kept
//   gt_in  : comparator verdict, 1 when value > trial
//   trial  : value driven to the comparator (0 when idle)
//   busy   : conversion in progress
//   done   : one-cycle pulse, result just updated
//   result : last completed level
module sar_level8
    import stress_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               gt_in,
    output logic [LEVEL_W-1:0] trial,
    output logic               busy,
    output logic               done,
    output logic [LEVEL_W-1:0] result
);

    state_t             state, state_n;
    logic [LEVEL_W-1:0] acc, acc_n;
    logic [LEVEL_W-1:0] result_n;
    logic [BIT_W-1:0]   k, k_n;
    logic               done_n;
    logic [LEVEL_W-1:0] cand;
    logic               accept, sample, tick;

    // Candidate sets bit k on top of the bits already resolved. Presenting
    // cand-1 under a strict '>' comparator means gt=1 exactly when
    // value >= cand, so keeping the bit on gt converges to value itself.
    assign cand  = acc | (LEVEL_W'(1) << k);
    assign busy  = (state == TEST);
    assign trial = busy ? cand - 1'b1 : '0;

    assign accept = (state == IDLE) && start && !abort;
    assign sample = (state == TEST) && !abort && tick;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (accept || sample),
        .en   (state == TEST),
        .tick (tick)
    );

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        k_n      = k;
        result_n = result;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = TEST;
                    acc_n   = '0;
                    k_n     = BIT_W'(LEVEL_W - 1);
                end
            end
            TEST: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (sample) begin
                    if (gt_in)
                        acc_n = cand;
                    if (k == '0) begin
                        result_n = acc_n;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        k_n = k - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            k      <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            k      <= k_n;
            result <= result_n;
            done   <= done_n;
        end
    end

endmodule
